// File: rtl/eth_cmd_arbiter_if.sv
// Bundle of requester-side and shared-bus-side signals of eth_cmd_arbiter.
//
// Handshake: a requester raises req_sel[i] with its rd_wr_n/byte_addr/wdata
// stable and keeps all of them stable until it sees req_ack[i] (a one-cycle
// pulse; req_rdata and req_timeout[i] are valid only in that cycle). On the
// shared bus, m_sel is held high with m_rd_wr_n/m_byte_addr/m_wdata stable
// until the slave raises m_ack for one cycle, with m_rdata valid alongside it.
//
// Modports:
//   master - the arbiter: consumes requests and m_ack/m_rdata, drives the
//            requester returns and the shared-bus command.
//   slave  - the environment: requesters plus the shared-bus slave.
interface eth_cmd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_sel;
  logic [NUM_REQ-1:0]        req_rd_wr_n;
  logic [NUM_REQ*ADDR_W-1:0] req_byte_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_timeout;
  logic                      m_sel;
  logic                      m_rd_wr_n;
  logic [ADDR_W-1:0]         m_byte_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_ack;
  logic [DATA_W-1:0]         m_rdata;

  modport master (
    input  req_sel, req_rd_wr_n, req_byte_addr, req_wdata, m_ack, m_rdata,
    output req_ack, req_rdata, req_timeout, m_sel, m_rd_wr_n, m_byte_addr, m_wdata
  );

  modport slave (
    output req_sel, req_rd_wr_n, req_byte_addr, req_wdata, m_ack, m_rdata,
    input  req_ack, req_rdata, req_timeout, m_sel, m_rd_wr_n, m_byte_addr, m_wdata
  );
endinterface

// File: rtl/eth_cmd_arbiter.sv
// Round-robin arbiter sharing one cmd-bus master port between NUM_REQ
// requesters. A granted request is registered onto the shared bus and held
// until m_ack (or until a programmable timeout aborts it); the completion is
// returned to the owning requester as a one-cycle req_ack pulse.
//
// Ports:
//   cmd_clock      - single clock
//   cmd_arst_n     - asynchronous active-low reset
//   bus            - requester and shared-bus signals (eth_cmd_arbiter_if.master)
//   grant          - one-hot current owner, 0 when idle
//   busy           - high in ACTIVE or RELEASE
//   timeout_count  - saturating count of aborted transactions
//   state_dbg      - current FSM state (0 IDLE, 1 ACTIVE, 2 RELEASE)
module eth_cmd_arbiter #(
  parameter int                 NUM_REQ        = 2,
  parameter int                 ADDR_W         = 16,
  parameter int                 DATA_W         = 32,
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_RDATA  = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                 cmd_clock,
  input  logic                 cmd_arst_n,
  eth_cmd_arbiter_if.master    bus,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [15:0]          timeout_count,
  output logic [1:0]           state_dbg
);

  localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the edge that ends the TIMEOUT_CYCLES-th ACTIVE cycle,
  // i.e. when the timer (cleared on grant) already shows TIMEOUT_CYCLES-1.
  localparam logic [TMR_W-1:0] TMR_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    owner_q, owner_n;
  logic [IDX_W-1:0]    last_q, last_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [NUM_REQ-1:0]  grant_q, grant_n;
  logic                busy_q, busy_n;
  logic [15:0]         tcount_q, tcount_n;
  logic                m_sel_q, m_sel_n;
  logic                m_rd_wr_n_q, m_rd_wr_n_n;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_n;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_n;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_n;
  logic [NUM_REQ-1:0]  req_tmo_q, req_tmo_n;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_n;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;
  logic                timeout_hit;

  // Round-robin pick: first set req_sel searching upward from last+1, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = 0;
    cand_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!pick_valid && bus.req_sel[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    last_n      = last_q;
    timer_n     = timer_q;
    grant_n     = grant_q;
    busy_n      = busy_q;
    tcount_n    = tcount_q;
    m_sel_n     = m_sel_q;
    m_rd_wr_n_n = m_rd_wr_n_q;
    m_addr_n    = m_addr_q;
    m_wdata_n   = m_wdata_q;
    req_ack_n   = '0;
    req_tmo_n   = '0;
    req_rdata_n = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_n           = pick_idx;
          last_n            = pick_idx;
          timer_n           = '0;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
          busy_n            = 1'b1;
          m_sel_n           = 1'b1;
          m_rd_wr_n_n       = bus.req_rd_wr_n[pick_idx];
          m_addr_n          = bus.req_byte_addr[pick_idx*ADDR_W +: ADDR_W];
          m_wdata_n         = bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          state_n           = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        // A real ack wins over a timeout landing on the same edge.
        if (bus.m_ack || timeout_hit) begin
          req_ack_n[owner_q] = 1'b1;
          grant_n            = '0;
          m_sel_n            = 1'b0;
          m_wdata_n          = '0;
          state_n            = ST_RELEASE;
          if (bus.m_ack) begin
            req_rdata_n = bus.m_rdata;
          end else begin
            req_rdata_n        = TIMEOUT_RDATA;
            req_tmo_n[owner_q] = 1'b1;
            if (tcount_q != 16'hFFFF) tcount_n = tcount_q + 16'd1;
          end
        end else if (timer_q != '1) begin
          timer_n = timer_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // No arbitration here, so an owner still holding req_sel for one
        // more cycle cannot be regranted straight away.
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end

      default: begin
        grant_n = '0;
        busy_n  = 1'b0;
        m_sel_n = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cmd_clock or negedge cmd_arst_n) begin
    if (!cmd_arst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= LAST_RST;
      timer_q     <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      tcount_q    <= '0;
      m_sel_q     <= 1'b0;
      m_rd_wr_n_q <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      req_ack_q   <= '0;
      req_tmo_q   <= '0;
      req_rdata_q <= '0;
    end else begin
      state_q     <= state_n;
      owner_q     <= owner_n;
      last_q      <= last_n;
      timer_q     <= timer_n;
      grant_q     <= grant_n;
      busy_q      <= busy_n;
      tcount_q    <= tcount_n;
      m_sel_q     <= m_sel_n;
      m_rd_wr_n_q <= m_rd_wr_n_n;
      m_addr_q    <= m_addr_n;
      m_wdata_q   <= m_wdata_n;
      req_ack_q   <= req_ack_n;
      req_tmo_q   <= req_tmo_n;
      req_rdata_q <= req_rdata_n;
    end
  end

  assign bus.m_sel       = m_sel_q;
  assign bus.m_rd_wr_n   = m_rd_wr_n_q;
  assign bus.m_byte_addr = m_addr_q;
  assign bus.m_wdata     = m_wdata_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.req_timeout = req_tmo_q;
  assign bus.req_rdata   = req_rdata_q;
  assign grant           = grant_q;
  assign busy            = busy_q;
  assign timeout_count   = tcount_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_eth_cmd_arbiter.sv
// Directed bench for eth_cmd_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_eth_cmd_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TMO     = 8;

  logic        cmd_clock;
  logic        cmd_arst_n;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] timeout_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  eth_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  eth_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO), .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .cmd_clock(cmd_clock),
    .cmd_arst_n(cmd_arst_n),
    .bus(bus_if),
    .grant(grant),
    .busy(busy),
    .timeout_count(timeout_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial cmd_clock = 1'b0;
  always #5 cmd_clock = ~cmd_clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge cmd_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cmd_arst_n = 1'b0;
    tick();
    tick();
    cmd_arst_n = 1'b1;
  endtask

  initial begin
    cmd_arst_n            = 1'b0;
    bus_if.req_sel        = '0;
    bus_if.req_rd_wr_n    = '0;
    bus_if.req_byte_addr  = '0;
    bus_if.req_wdata      = '0;
    bus_if.m_ack          = 1'b0;
    bus_if.m_rdata        = '0;

    // reset state
    tick();
    tick();
    chk("rst_m_sel", bus_if.m_sel, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ack", bus_if.req_ack, 2'b00);
    chk("rst_tcount", timeout_count, 16'd0);
    chk("rst_state", state_dbg, 2'd0);
    cmd_arst_n = 1'b1;
    tick();

    // single write: req 0 writes 0x1234 to 0x0000, slave acks after 3 cycles
    bus_if.req_sel[0]              = 1'b1;
    bus_if.req_rd_wr_n[0]          = 1'b0;
    bus_if.req_byte_addr[15:0]     = 16'h0000;
    bus_if.req_wdata[31:0]         = 32'h0000_1234;
    tick();
    chk("wr_m_sel", bus_if.m_sel, 1'b1);
    chk("wr_grant", grant, 2'b01);
    chk("wr_busy", busy, 1'b1);
    chk("wr_m_wdata", bus_if.m_wdata, 32'h1234);
    chk("wr_m_rd_wr_n", bus_if.m_rd_wr_n, 1'b0);
    chk("wr_state", state_dbg, 2'd1);
    tick();
    tick();
    chk("wr_hold_m_sel", bus_if.m_sel, 1'b1);
    chk("wr_hold_ack", bus_if.req_ack, 2'b00);
    bus_if.m_ack   = 1'b1;
    bus_if.m_rdata = 32'h0;
    tick();
    chk("wr_req_ack", bus_if.req_ack, 2'b01);
    chk("wr_req_tmo", bus_if.req_timeout, 2'b00);
    chk("wr_rel_m_sel", bus_if.m_sel, 1'b0);
    chk("wr_rel_grant", grant, 2'b00);
    chk("wr_rel_wdata", bus_if.m_wdata, 32'h0);
    chk("wr_rel_busy", busy, 1'b1);
    chk("wr_rel_state", state_dbg, 2'd2);
    bus_if.m_ack      = 1'b0;
    bus_if.req_sel[0] = 1'b0;
    tick();
    chk("wr_idle_ack", bus_if.req_ack, 2'b00);
    chk("wr_idle_busy", busy, 1'b0);
    chk("wr_idle_state", state_dbg, 2'd0);

    // read returning 0x00001234, then spurious m_ack in RELEASE and IDLE
    bus_if.req_sel[0]          = 1'b1;
    bus_if.req_rd_wr_n[0]      = 1'b1;
    bus_if.req_byte_addr[15:0] = 16'h0004;
    tick();
    chk("rd_m_sel", bus_if.m_sel, 1'b1);
    chk("rd_m_rd_wr_n", bus_if.m_rd_wr_n, 1'b1);
    chk("rd_m_addr", bus_if.m_byte_addr, 16'h0004);
    bus_if.m_ack   = 1'b1;
    bus_if.m_rdata = 32'h0000_1234;
    tick();
    chk("rd_req_ack", bus_if.req_ack, 2'b01);
    chk("rd_req_rdata", bus_if.req_rdata, 32'h0000_1234);
    bus_if.req_sel[0] = 1'b0;
    bus_if.m_rdata    = 32'h7777_7777;
    tick();
    chk("spur_rel_ack", bus_if.req_ack, 2'b00);
    chk("spur_rel_state", state_dbg, 2'd0);
    tick();
    chk("spur_idle_ack", bus_if.req_ack, 2'b00);
    chk("spur_idle_state", state_dbg, 2'd0);
    chk("spur_idle_m_sel", bus_if.m_sel, 1'b0);
    bus_if.m_ack = 1'b0;

    // contention from reset: grants rotate 0,1,0,1,0,1
    do_reset();
    bus_if.req_sel              = 2'b11;
    bus_if.req_rd_wr_n          = 2'b11;
    bus_if.req_byte_addr[15:0]  = 16'h0010;
    bus_if.req_byte_addr[31:16] = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  exp_g;
      logic [15:0] exp_a;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 16'h0010 : 16'h0020;
      tick();
      chk($sformatf("rr_grant_%0d", i), grant, exp_g);
      chk($sformatf("rr_addr_%0d", i), bus_if.m_byte_addr, exp_a);
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'h100 + i;
      tick();
      chk($sformatf("rr_ack_%0d", i), bus_if.req_ack, exp_g);
      chk($sformatf("rr_rdata_%0d", i), bus_if.req_rdata, 32'h100 + i);
      bus_if.m_ack = 1'b0;
      tick();
      chk($sformatf("rr_gap_%0d", i), bus_if.m_sel, 1'b0);
    end
    bus_if.req_sel = 2'b00;
    tick();

    // timeout: slave never acks
    do_reset();
    bus_if.req_sel     = 2'b01;
    bus_if.req_rd_wr_n = 2'b01;
    tick();
    chk("tmo_grant", grant, 2'b01);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_pre_ack", bus_if.req_ack, 2'b00);
    tick();
    chk("tmo_ack", bus_if.req_ack, 2'b01);
    chk("tmo_flag", bus_if.req_timeout, 2'b01);
    chk("tmo_rdata", bus_if.req_rdata, 32'hDEAD_BEEF);
    chk("tmo_count", timeout_count, 16'd1);
    bus_if.req_sel = 2'b00;
    tick();
    chk("tmo_flag_clr", bus_if.req_timeout, 2'b00);

    // next request served normally
    bus_if.req_sel = 2'b01;
    tick();
    bus_if.m_ack   = 1'b1;
    bus_if.m_rdata = 32'h0000_A5A5;
    tick();
    chk("post_tmo_ack", bus_if.req_ack, 2'b01);
    chk("post_tmo_flag", bus_if.req_timeout, 2'b00);
    chk("post_tmo_rdata", bus_if.req_rdata, 32'h0000_A5A5);
    chk("post_tmo_count", timeout_count, 16'd1);
    bus_if.m_ack   = 1'b0;
    bus_if.req_sel = 2'b00;
    tick();

    // ack on the exact timeout edge; owner also drops req_sel early
    bus_if.req_sel = 2'b01;
    tick();
    chk("col_grant", grant, 2'b01);
    bus_if.req_sel = 2'b00;
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("col_still_busy", bus_if.m_sel, 1'b1);
    bus_if.m_ack   = 1'b1;
    bus_if.m_rdata = 32'h5555_5555;
    tick();
    chk("col_ack", bus_if.req_ack, 2'b01);
    chk("col_flag", bus_if.req_timeout, 2'b00);
    chk("col_rdata", bus_if.req_rdata, 32'h5555_5555);
    chk("col_count", timeout_count, 16'd1);
    bus_if.m_ack = 1'b0;
    tick();

    // reset mid-transaction
    bus_if.req_sel = 2'b10;
    tick();
    tick();
    chk("mid_grant", grant, 2'b10);
    #2;
    cmd_arst_n = 1'b0;
    #1;
    chk("arst_m_sel", bus_if.m_sel, 1'b0);
    chk("arst_grant", grant, 2'b00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ack", bus_if.req_ack, 2'b00);
    bus_if.req_sel = 2'b11;
    tick();
    cmd_arst_n = 1'b1;
    tick();
    chk("post_rst_grant", grant, 2'b01);
    bus_if.m_ack   = 1'b1;
    bus_if.m_rdata = 32'h0;
    tick();
    chk("post_rst_ack", bus_if.req_ack, 2'b01);
    bus_if.m_ack   = 1'b0;
    bus_if.req_sel = 2'b00;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
